// File: rtl/proc_ctrl_pkg.sv
// Shared opcode and FSM step encodings for the processor control unit.
package proc_ctrl_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

endpackage

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// 3-to-8 one-hot decoder with enable; selects a register from an IR field.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    assign y = en ? (8'b0000_0001 << w) : 8'b0000_0000;

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM for the 8-register shared-bus datapath (mv/mvi/add/sub).
// Define PROC_CTRL_ICNT_EN to add the completed-instruction counter port instr_count.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              P_clock,
    input  logic              reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [7:0]        IR,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic              Busy
`ifdef PROC_CTRL_ICNT_EN
    ,
    output logic [CNT_W-1:0]  instr_count
`endif
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] x_oh;
    logic [7:0] y_oh;
    logic [1:0] op;

    assign op = IR[7:6];

    dec3to8 u_dec_x (
        .w  (IR[5:3]),
        .en (1'b1),
        .y  (x_oh)
    );

    dec3to8 u_dec_y (
        .w  (IR[2:0]),
        .en (1'b1),
        .y  (y_oh)
    );

    // Run is only honoured in T0; IR is frozen for the rest of the instruction.
    always_ff @(posedge P_clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            IR    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == T0 && Run) begin
                IR <= DIN[7:0];
            end
        end
    end

    always_comb begin
        state_nxt = T0;
        Rin       = 8'h00;
        Rout      = 8'h00;
        DINout    = 1'b0;
        Gout      = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;
        case (state)
            T0: begin
                state_nxt = Run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = x_oh;
                        Done   = 1'b1;
                    end
                    default: begin
                        Rout      = x_oh;
                        Ain       = 1'b1;
                        state_nxt = T2;
                    end
                endcase
            end
            T2: begin
                // Only add/sub can reach T2; anything else falls back to T0 harmlessly.
                if (op == OP_ADD || op == OP_SUB) begin
                    Rout      = y_oh;
                    Gin       = 1'b1;
                    AddSub    = IR[6];
                    state_nxt = T3;
                end
            end
            T3: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    Gout = 1'b1;
                    Rin  = x_oh;
                    Done = 1'b1;
                end
            end
            default: state_nxt = T0;
        endcase
    end

    assign Busy = (state != T0);

`ifdef PROC_CTRL_ICNT_EN
    always_ff @(posedge P_clock or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (Done) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
